bcd_counter_2dig: RTL and testbench
===================================

Name: bcd_counter_2dig

Overview:
Two-digit BCD up/down counter with an integrated prescaler. It produces the units and tens digit values that feed a pair of 7-segment decoder stages. It also produces a one-cycle step pulse marking each count update. It sits directly upstream of the display decoders and replaces ad-hoc counters in the lab top levels.

Parameters:
DIV, 50000000, prescaler division ratio: one count step per DIV clock cycles (legal range 1..2^26).
MODULO, 100, count range 0..MODULO-1 (legal range 2..100, e.g. 60 for seconds).

Ports:
clock  input  1  system clock, rising edge.
reset_n  input  1  asynchronous active-low reset.
enable  input  1  counting permitted when high.
up  input  1  1 = count up, 0 = count down; sampled on step cycles.
clear  input  1  synchronous clear of digits and prescaler.
load  input  1  synchronous parallel load.
load_tens  input  4  tens digit for load.
load_units  input  4  units digit for load.
tens  output  4  BCD tens digit, registered.
units  output  4  BCD units digit, registered.
step  output  1  registered one-cycle pulse, high in the cycle after a count update.
wrap  output  1  registered one-cycle pulse, high in the cycle after a wrap (up past MODULO-1, or down past 0).

Behaviour:
- Reset (reset_n low, asynchronous): tens=0, units=0, step=0, wrap=0, prescaler count=0. Outputs hold these values while reset_n is low.
- Prescaler: counter pre runs 0..DIV-1 while enable=1 and frozen while enable=0.
  - The prescaler runs independently of load; clear resets it to 0.
  - Step condition S = enable and (pre == DIV-1). On S, pre goes to 0.
  - With DIV=1, S = enable on every cycle.
- Count update on S, with value V = 10*tens + units:
  - up=1: V goes to V+1, or to 0 if V == MODULO-1, with wrap asserted.
  - up=0: V goes to V-1, or to MODULO-1 if V == 0, with wrap asserted.
- Digit arithmetic is performed per digit in BCD, with no binary-to-BCD divider:
  - units 9 -> 0 with a tens increment.
  - units 0 -> 9 with a tens decrement.
  - The MODULO boundary is handled as a full-value compare.
- Latency: digits change on the same rising edge where S holds. step (and wrap, if applicable) is high for exactly the next cycle.
- Priority on each edge: clear > load > count step.
  - clear: digits=0, pre=0, step=0, wrap=0.
  - load: tens=load_tens, units=load_units, step=0, wrap=0; pre continues unchanged.
  - If S coincides with clear or load, the count step is discarded and no step pulse is produced.
- Load sanitising:
  - Any digit >9 loads as 0.
  - If the sanitised value is >= MODULO, both digits load as 0.
- Invariant: outputs are always valid BCD and V < MODULO at all times. Downstream decoders never see codes 10..15.
- enable low: digits and pre hold; step and wrap are 0. clear and load still act.
- up changing mid-period has no effect until the next S.
- Reset asserted mid-period: all state returns to 0 immediately. After release, the first step occurs DIV cycles after the first enabled cycle.

Test Plan:
- DIV=4, MODULO=100, reset then enable=1, up=1 -> step pulses every 4 cycles; digits 00,01,...,09,10 (units 9->0, tens 0->1); wrap stays 0.
- DIV=1, MODULO=60, up=1 from load 5,9 -> next step gives 0,0 with wrap=1 for one cycle; the following step gives 0,1 with wrap=0.
- DIV=1, MODULO=60, up=0 from 0,0 -> 5,9 with wrap=1; then 5,8; and from 1,0 -> 0,9.
- Load 12,3 (tens=12, units=3) -> 0,3. Load 7,0 with MODULO=60 -> 0,0. Load 4,2 coincident with S -> 4,2 held, no step pulse. clear coincident with load -> 0,0.
- DIV=4: enable low for 10 cycles mid-period -> digits and pre frozen; the step resumes after the remaining prescaler cycles once enable returns.
- Assert reset_n low asynchronously between clock edges at value 4,7 -> outputs go to 0 immediately (before the next edge); after release, the first step occurs at the 4th enabled cycle.

Source files
------------

// File: rtl/bcd_counter_2dig_if.sv
// Control and digit signals between the BCD counter and whatever drives and
// observes it. Clock and reset stay plain ports on the counter.
interface bcd_counter_2dig_if;
    logic       enable;
    logic       up;
    logic       clear;
    logic       load;
    logic [3:0] load_tens;
    logic [3:0] load_units;
    logic [3:0] tens;
    logic [3:0] units;
    logic       step;
    logic       wrap;

    modport master (
        output enable, up, clear, load, load_tens, load_units,
        input  tens, units, step, wrap
    );

    modport slave (
        input  enable, up, clear, load, load_tens, load_units,
        output tens, units, step, wrap
    );
endinterface

// File: rtl/bcd_counter_2dig.sv
// Two-digit BCD up/down counter with prescaler, feeding the 7-segment decoders.
// Digits are kept in BCD per digit; the MODULO boundary is a full-value compare.
module bcd_counter_2dig #(
    parameter int DIV    = 50000000,
    parameter int MODULO = 100
) (
    input logic               clock,
    input logic               reset_n,
    bcd_counter_2dig_if.slave bus
);
    localparam int               PRE_W     = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [PRE_W-1:0] PRE_LAST  = PRE_W'(DIV - 1);
    localparam logic [PRE_W-1:0] PRE_ONE   = PRE_W'(1);
    localparam logic [3:0]       MAX_TENS  = 4'((MODULO - 1) / 10);
    localparam logic [3:0]       MAX_UNITS = 4'((MODULO - 1) % 10);

    logic [PRE_W-1:0] pre;
    logic             s;
    logic             at_top;
    logic             at_zero;
    logic             boundary;
    logic [3:0]       cnt_tens;
    logic [3:0]       cnt_units;
    logic [3:0]       ld_tens_d;
    logic [3:0]       ld_units_d;
    logic [3:0]       ld_tens;
    logic [3:0]       ld_units;

    assign s        = bus.enable && (pre == PRE_LAST);
    assign at_top   = (bus.tens == MAX_TENS) && (bus.units == MAX_UNITS);
    assign at_zero  = (bus.tens == 4'd0) && (bus.units == 4'd0);
    assign boundary = bus.up ? at_top : at_zero;

    always_comb begin
        cnt_tens  = bus.tens;
        cnt_units = bus.units;
        if (bus.up) begin
            if (at_top) begin
                cnt_tens  = 4'd0;
                cnt_units = 4'd0;
            end else if (bus.units == 4'd9) begin
                cnt_units = 4'd0;
                cnt_tens  = bus.tens + 4'd1;
            end else begin
                cnt_units = bus.units + 4'd1;
            end
        end else begin
            if (at_zero) begin
                cnt_tens  = MAX_TENS;
                cnt_units = MAX_UNITS;
            end else if (bus.units == 4'd0) begin
                cnt_units = 4'd9;
                cnt_tens  = bus.tens - 4'd1;
            end else begin
                cnt_units = bus.units - 4'd1;
            end
        end
    end

    // Non-BCD digits become 0, then anything at or above MODULO becomes 00.
    always_comb begin
        ld_tens_d  = (bus.load_tens  > 4'd9) ? 4'd0 : bus.load_tens;
        ld_units_d = (bus.load_units > 4'd9) ? 4'd0 : bus.load_units;
        ld_tens    = ld_tens_d;
        ld_units   = ld_units_d;
        if ((ld_tens_d > MAX_TENS) ||
            ((ld_tens_d == MAX_TENS) && (ld_units_d > MAX_UNITS))) begin
            ld_tens  = 4'd0;
            ld_units = 4'd0;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            pre <= '0;
        end else if (bus.clear) begin
            pre <= '0;
        end else if (bus.enable) begin
            if (s) pre <= '0;
            else   pre <= pre + PRE_ONE;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            bus.tens  <= 4'd0;
            bus.units <= 4'd0;
            bus.step  <= 1'b0;
            bus.wrap  <= 1'b0;
        end else if (bus.clear) begin
            bus.tens  <= 4'd0;
            bus.units <= 4'd0;
            bus.step  <= 1'b0;
            bus.wrap  <= 1'b0;
        end else if (bus.load) begin
            bus.tens  <= ld_tens;
            bus.units <= ld_units;
            bus.step  <= 1'b0;
            bus.wrap  <= 1'b0;
        end else if (s) begin
            bus.tens  <= cnt_tens;
            bus.units <= cnt_units;
            bus.step  <= 1'b1;
            bus.wrap  <= boundary;
        end else begin
            bus.step  <= 1'b0;
            bus.wrap  <= 1'b0;
        end
    end
endmodule

// File: tb/tb_bcd_counter_2dig.sv
// Bench for bcd_counter_2dig: one instance at DIV=4/MODULO=100, one at DIV=1/MODULO=60,
// each checked every cycle against an integer-valued model plus directed literal checks.
module tb_bcd_counter_2dig;
    logic clk;
    logic rst_n;
    int   total = 0;
    int   bad   = 0;

    bcd_counter_2dig_if ia ();
    bcd_counter_2dig_if ib ();

    bcd_counter_2dig #(.DIV(4), .MODULO(100)) dut_a (.clock(clk), .reset_n(rst_n), .bus(ia));
    bcd_counter_2dig #(.DIV(1), .MODULO(60))  dut_b (.clock(clk), .reset_n(rst_n), .bus(ib));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int v;
        int pre;
        int st;
        int wr;
    } mstate_t;

    mstate_t ma;
    mstate_t mb;

    function automatic mstate_t mnext(mstate_t m, int div, int modulo, bit en, bit up,
                                      bit clr, bit ld, int lt, int lu);
        mstate_t n;
        bit      s;
        int      t;
        int      u;
        n    = m;
        n.st = 0;
        n.wr = 0;
        s    = en && (m.pre == div - 1);
        if (en) n.pre = s ? 0 : m.pre + 1;
        if (clr) begin
            n.v   = 0;
            n.pre = 0;
        end else if (ld) begin
            t   = (lt > 9) ? 0 : lt;
            u   = (lu > 9) ? 0 : lu;
            n.v = (t * 10 + u >= modulo) ? 0 : t * 10 + u;
        end else if (s) begin
            n.st = 1;
            if (up) begin
                if (m.v == modulo - 1) begin n.v = 0; n.wr = 1; end
                else n.v = m.v + 1;
            end else begin
                if (m.v == 0) begin n.v = modulo - 1; n.wr = 1; end
                else n.v = m.v - 1;
            end
        end
        return n;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ma = '{default: 0};
            mb = '{default: 0};
        end else begin
            ma = mnext(ma, 4, 100, ia.enable, ia.up, ia.clear, ia.load,
                       int'(ia.load_tens), int'(ia.load_units));
            mb = mnext(mb, 1, 60, ib.enable, ib.up, ib.clear, ib.load,
                       int'(ib.load_tens), int'(ib.load_units));
        end
    end

    task automatic chk(string name, int act, int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        chk("model_a_tens",  int'(ia.tens),  ma.v / 10);
        chk("model_a_units", int'(ia.units), ma.v % 10);
        chk("model_a_step",  int'(ia.step),  ma.st);
        chk("model_a_wrap",  int'(ia.wrap),  ma.wr);
        chk("model_b_tens",  int'(ib.tens),  mb.v / 10);
        chk("model_b_units", int'(ib.units), mb.v % 10);
        chk("model_b_step",  int'(ib.step),  mb.st);
        chk("model_b_wrap",  int'(ib.wrap),  mb.wr);
    end

    task automatic exp_a(string n, int v, int st, int wr);
        chk({n, "_tens"},  int'(ia.tens),  v / 10);
        chk({n, "_units"}, int'(ia.units), v % 10);
        chk({n, "_step"},  int'(ia.step),  st);
        chk({n, "_wrap"},  int'(ia.wrap),  wr);
    endtask

    task automatic exp_b(string n, int v, int st, int wr);
        chk({n, "_tens"},  int'(ib.tens),  v / 10);
        chk({n, "_units"}, int'(ib.units), v % 10);
        chk({n, "_step"},  int'(ib.step),  st);
        chk({n, "_wrap"},  int'(ib.wrap),  wr);
    endtask

    task automatic load_a(int t, int u);
        ia.load_tens = 4'(t); ia.load_units = 4'(u); ia.load = 1'b1;
        @(negedge clk);
        ia.load = 1'b0;
    endtask

    task automatic load_b(int t, int u);
        ib.load_tens = 4'(t); ib.load_units = 4'(u); ib.load = 1'b1;
        @(negedge clk);
        ib.load = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0;
        ia.enable = 0; ia.up = 0; ia.clear = 0; ia.load = 0; ia.load_tens = 0; ia.load_units = 0;
        ib.enable = 0; ib.up = 0; ib.clear = 0; ib.load = 0; ib.load_tens = 0; ib.load_units = 0;
        repeat (2) @(negedge clk);
        exp_a("rst_a", 0, 0, 0);
        exp_b("rst_b", 0, 0, 0);
        rst_n = 1'b1;

        // DIV=4 count-up through the units carry
        ia.enable = 1; ia.up = 1;
        for (int k = 1; k <= 10; k++) begin
            repeat (4) @(negedge clk);
            exp_a($sformatf("up_seq%0d", k), k, 1, 0);
        end
        repeat (2) @(negedge clk);
        ia.enable = 0;
        repeat (10) @(negedge clk);
        exp_a("frozen", 10, 0, 0);
        ia.enable = 1;
        repeat (2) @(negedge clk);
        exp_a("resume", 11, 1, 0);
        ia.enable = 0;

        load_a(9, 9);
        exp_a("ld99", 99, 0, 0);
        ia.enable = 1;
        repeat (4) @(negedge clk);
        exp_a("wrap_up_a", 0, 1, 1);
        ia.enable = 0;
        load_a(12, 3);
        exp_a("ld_12_3_a", 3, 0, 0);

        // DIV=1, MODULO=60
        load_b(5, 9);
        exp_b("ld59", 59, 0, 0);
        ib.enable = 1; ib.up = 1;
        @(negedge clk);
        exp_b("wrap_up", 0, 1, 1);
        @(negedge clk);
        exp_b("after_wrap", 1, 1, 0);
        ib.enable = 0;
        ib.clear = 1;
        @(negedge clk);
        ib.clear = 0;
        exp_b("clr", 0, 0, 0);
        ib.enable = 1; ib.up = 0;
        @(negedge clk);
        exp_b("wrap_dn", 59, 1, 1);
        @(negedge clk);
        exp_b("dn", 58, 1, 0);
        ib.enable = 0;
        load_b(1, 0);
        exp_b("ld10", 10, 0, 0);
        ib.enable = 1;
        @(negedge clk);
        exp_b("borrow", 9, 1, 0);
        ib.enable = 0;
        load_b(12, 3);
        exp_b("ld_12_3_b", 3, 0, 0);
        load_b(7, 0);
        exp_b("ld70", 0, 0, 0);

        ib.enable = 1; ib.up = 1;
        load_b(4, 2);
        ib.enable = 0;
        exp_b("ld_s", 42, 0, 0);
        @(negedge clk);
        exp_b("ld_s_hold", 42, 0, 0);
        ib.clear = 1;
        load_b(3, 3);
        ib.clear = 0;
        exp_b("clr_ld", 0, 0, 0);

        // asynchronous reset between edges
        load_a(4, 7);
        exp_a("ld47", 47, 0, 0);
        #2 rst_n = 1'b0;
        #1 exp_a("async_rst", 0, 0, 0);
        @(negedge clk);
        rst_n = 1'b1;
        ia.enable = 1; ia.up = 1;
        repeat (3) @(negedge clk);
        exp_a("rel_pre", 0, 0, 0);
        @(negedge clk);
        exp_a("rel_step", 1, 1, 0);
        ia.enable = 0;
        repeat (2) @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
